// File: rtl/chain_power_sequencer_if.sv
// Connector-side bundle of the chain power sequencer: PS run requests and raw
// board presence in, per-chain EN/RST_N/READY/FAULT and the scheduler BUSY flag out.
interface chain_power_sequencer_if #(
    parameter int N_CHAINS = 9
);
    logic [N_CHAINS-1:0] plug;
    logic [N_CHAINS-1:0] run_req;
    logic [N_CHAINS-1:0] en;
    logic [N_CHAINS-1:0] rst_n;
    logic [N_CHAINS-1:0] ready;
    logic [N_CHAINS-1:0] fault;
    logic                busy;

    modport master (
        output plug, run_req,
        input  en, rst_n, ready, fault, busy
    );

    modport slave (
        input  plug, run_req,
        output en, rst_n, ready, fault, busy
    );
endinterface

// File: rtl/chain_power_sequencer.sv
// Staggered hash-board power-up: one chain at a time through EN -> SETTLE_CYC -> RST_N release -> GAP_CYC,
// with immediate per-chain teardown. Define CHAIN_PLUG_DEBOUNCE_EN to debounce the synchronized PLUG inputs.
module chain_power_sequencer #(
    parameter int N_CHAINS     = 9,
    parameter int SETTLE_CYC   = 5_000_000,
    parameter int GAP_CYC      = 10_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    chain_power_sequencer_if.slave bus
);
    localparam int PTR_W   = (N_CHAINS > 1) ? $clog2(N_CHAINS) : 1;
    localparam int CNT_MAX = (SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        SCAN,
        POWER,
        GAP
    } state_e;

    if (SETTLE_CYC < 1 || GAP_CYC < 1 || DEBOUNCE_CYC < 1 || N_CHAINS < 2) begin : g_bad_param
        $error("chain_power_sequencer: N_CHAINS >= 2 and all cycle counts >= 1 required");
    end

    logic [N_CHAINS-1:0] plug_s1_q;
    logic [N_CHAINS-1:0] plug_s2_q;
    logic [N_CHAINS-1:0] plug_ok;

    logic [N_CHAINS-1:0] en_q;
    logic [N_CHAINS-1:0] rst_n_q;
    logic [N_CHAINS-1:0] ready_q;
    logic [N_CHAINS-1:0] fault_q;
    logic                busy_q;
    state_e              state_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    cur_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [N_CHAINS-1:0] cand_d;
    logic [N_CHAINS-1:0] td_d;
    logic                grant_vld_d;
    logic [PTR_W-1:0]    grant_idx_d;
    logic [PTR_W:0]      rr_sum_d;
    logic                abort_d;
    logic [PTR_W-1:0]    ptr_nxt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            plug_s1_q <= '0;
            plug_s2_q <= '0;
        end else begin
            plug_s1_q <= bus.plug;
            plug_s2_q <= plug_s1_q;
        end
    end

`ifdef CHAIN_PLUG_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

    logic [N_CHAINS-1:0] plug_ok_q;
    logic [DB_W-1:0]     db_cnt_q [N_CHAINS];

    // plug_ok follows the synchronizer only after DEBOUNCE_CYC consecutive disagreeing cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            plug_ok_q <= '0;
            for (int k = 0; k < N_CHAINS; k++) begin
                db_cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CHAINS; k++) begin
                if (plug_s2_q[k] != plug_ok_q[k]) begin
                    if (db_cnt_q[k] == DB_W'(DEBOUNCE_CYC - 1)) begin
                        plug_ok_q[k] <= plug_s2_q[k];
                        db_cnt_q[k]  <= '0;
                    end else begin
                        db_cnt_q[k] <= db_cnt_q[k] + 1'b1;
                    end
                end else begin
                    db_cnt_q[k] <= '0;
                end
            end
        end
    end

    assign plug_ok = plug_ok_q;
`else
    assign plug_ok = plug_s2_q;
`endif

    // Round-robin pick: iterate offsets high to low so the smallest offset from ptr wins.
    always_comb begin
        cand_d      = bus.run_req & plug_ok & ~en_q & ~fault_q;
        td_d        = en_q & (~bus.run_req | ~plug_ok);
        grant_vld_d = 1'b0;
        grant_idx_d = '0;
        rr_sum_d    = '0;
        for (int i = N_CHAINS - 1; i >= 0; i--) begin
            rr_sum_d = {1'b0, ptr_q} + (PTR_W + 1)'(i);
            if (rr_sum_d >= (PTR_W + 1)'(N_CHAINS)) begin
                rr_sum_d = rr_sum_d - (PTR_W + 1)'(N_CHAINS);
            end
            if (cand_d[rr_sum_d[PTR_W-1:0]]) begin
                grant_vld_d = 1'b1;
                grant_idx_d = rr_sum_d[PTR_W-1:0];
            end
        end
        abort_d   = (state_q == POWER) && td_d[cur_q];
        ptr_nxt_d = (cur_q == PTR_W'(N_CHAINS - 1)) ? '0 : cur_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q    <= '0;
            rst_n_q <= '0;
            ready_q <= '0;
            fault_q <= '0;
            busy_q  <= 1'b0;
            state_q <= SCAN;
            ptr_q   <= '0;
            cur_q   <= '0;
            cnt_q   <= '0;
        end else begin
            // Teardown never touches a granted chain: grant requires run_req and plug_ok.
            for (int k = 0; k < N_CHAINS; k++) begin
                if (td_d[k]) begin
                    en_q[k]    <= 1'b0;
                    rst_n_q[k] <= 1'b0;
                    ready_q[k] <= 1'b0;
                end
                if (!bus.run_req[k]) begin
                    fault_q[k] <= 1'b0;
                end else if (td_d[k] && !plug_ok[k]) begin
                    fault_q[k] <= 1'b1;
                end
            end

            case (state_q)
                SCAN: begin
                    if (grant_vld_d) begin
                        en_q[grant_idx_d] <= 1'b1;
                        cur_q   <= grant_idx_d;
                        cnt_q   <= '0;
                        state_q <= POWER;
                        busy_q  <= 1'b1;
                    end
                end
                POWER: begin
                    if (abort_d) begin
                        cnt_q   <= '0;
                        ptr_q   <= ptr_nxt_d;
                        state_q <= GAP;
                    end else if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                        rst_n_q[cur_q] <= 1'b1;
                        ready_q[cur_q] <= 1'b1;
                        cnt_q   <= '0;
                        ptr_q   <= ptr_nxt_d;
                        state_q <= GAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                        cnt_q   <= '0;
                        state_q <= SCAN;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= SCAN;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.en    = en_q;
    assign bus.rst_n = rst_n_q;
    assign bus.ready = ready_q;
    assign bus.fault = fault_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_chain_power_sequencer.sv
// Directed bench for chain_power_sequencer: expected pin events are queued as stimulus is applied and
// checked by a negedge monitor that detects EN/RST_N/FAULT transitions.
module tb_chain_power_sequencer;
    localparam int N      = 9;
    localparam int SETTLE = 8;
    localparam int GAPC   = 4;
`ifdef CHAIN_PLUG_DEBOUNCE_EN
    localparam int DB = 3;
`else
    localparam int DB = 0;
`endif
    localparam int GL = (DB >= 1) ? DB - 1 : 0;

    typedef enum int {EV_EN_UP, EV_EN_DN, EV_RSTN_UP, EV_FAULT_UP, EV_FAULT_DN} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       chain;
        int       dt;
        int       at;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_ev = 0;
    int   c;
    int   g;
    ev_t  exp_q[$];
    logic [N-1:0] en_prev = '0;
    logic [N-1:0] rstn_prev = '0;
    logic [N-1:0] fault_prev = '0;

    chain_power_sequencer_if #(.N_CHAINS(N)) bus ();

    chain_power_sequencer #(
        .N_CHAINS    (N),
        .SETTLE_CYC  (SETTLE),
        .GAP_CYC     (GAPC),
        .DEBOUNCE_CYC(3)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string tag, int obs, int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic push(ev_kind_e kd, int ch, int dt, int at);
        ev_t e;
        e.kind = kd; e.chain = ch; e.dt = dt; e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic got(ev_kind_e kd, int k);
        ev_t e;
        chk("ev_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ev_kind", int'(kd), int'(e.kind));
            chk("ev_chain", k, e.chain);
            if (e.dt >= 0) chk("ev_dt", cyc - last_ev, e.dt);
            if (e.at >= 0) chk("ev_at", cyc, e.at);
        end
        chk("ev_ready", int'(bus.ready[k]), int'(bus.rst_n[k] & bus.en[k]));
        last_ev = cyc;
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (bus.en[k] === 1'b1 && !en_prev[k]) got(EV_EN_UP, k);
            if (bus.en[k] === 1'b0 && en_prev[k]) got(EV_EN_DN, k);
            if (bus.rst_n[k] === 1'b1 && !rstn_prev[k]) got(EV_RSTN_UP, k);
            if (bus.fault[k] === 1'b1 && !fault_prev[k]) got(EV_FAULT_UP, k);
            if (bus.fault[k] === 1'b0 && fault_prev[k]) got(EV_FAULT_DN, k);
        end
        en_prev    = bus.en;
        rstn_prev  = bus.rst_n;
        fault_prev = bus.fault;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_q(string tag, int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic wait_en(int k, int budget);
        int n = 0;
        while (bus.en[k] !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("wait_en", int'(bus.en[k]), 1);
    endtask

    initial begin
        rst         = 1'b1;
        bus.plug    = 9'h1FF;
        bus.run_req = 9'h1FF;

        // Power-up from reset: chains 0..8 in order with fixed settle and gap spacing.
        push(EV_EN_UP, 0, -1, 2 + 3 + DB);
        push(EV_RSTN_UP, 0, SETTLE, -1);
        for (int k = 1; k < N; k++) begin
            push(EV_EN_UP, k, GAPC + 1, -1);
            push(EV_RSTN_UP, k, SETTLE, -1);
        end
        tick();
        chk("rst_en", int'(bus.en), 0);
        chk("rst_rstn", int'(bus.rst_n), 0);
        chk("rst_ready", int'(bus.ready), 0);
        chk("rst_fault", int'(bus.fault), 0);
        chk("rst_busy", int'(bus.busy), 0);
        tick();
        chk("rst2_en", int'(bus.en), 0);
        chk("rst2_busy", int'(bus.busy), 0);
        rst = 1'b0;
        wait_q("seq_all", 300);
        chk("all_ready", int'(bus.ready), 9'h1FF);

        // Drop all requests, then chain 2 followed by a late request on chain 8.
        c = cyc;
        bus.run_req = 9'h000;
        for (int k = 0; k < N; k++) push(EV_EN_DN, k, -1, c + 1);
        wait_q("drop_all", 20);
        chk("drop_rstn", int'(bus.rst_n), 0);
        chk("drop_ready", int'(bus.ready), 0);
        repeat (6) tick();
        c = cyc;
        bus.run_req = 9'h004;
        push(EV_EN_UP, 2, -1, c + 1);
        push(EV_RSTN_UP, 2, SETTLE, -1);
        wait_en(2, 10);
        repeat (2) tick();
        chk("mid_power_busy", int'(bus.busy), 1);
        bus.run_req = 9'h104;
        push(EV_EN_UP, 8, GAPC + 1, -1);
        push(EV_RSTN_UP, 8, SETTLE, -1);
        wait_q("chain2_then_8", 60);

        // Chain 3 up, short plug glitch ignored, long plug loss faults the chain.
        repeat (6) tick();
        c = cyc;
        bus.run_req = 9'h10C;
        push(EV_EN_UP, 3, -1, c + 1);
        push(EV_RSTN_UP, 3, SETTLE, -1);
        wait_q("chain3_up", 40);
        repeat (6) tick();
        chk("c3_ready", int'(bus.ready[3]), 1);
        if (GL > 0) begin
            bus.plug[3] = 1'b0;
            repeat (GL) tick();
            bus.plug[3] = 1'b1;
        end
        repeat (10) tick();
        chk("glitch_en", int'(bus.en[3]), 1);
        chk("glitch_ready", int'(bus.ready[3]), 1);
        chk("glitch_fault", int'(bus.fault[3]), 0);
        c = cyc;
        bus.plug[3] = 1'b0;
        push(EV_EN_DN, 3, -1, c + 3 + DB);
        push(EV_FAULT_UP, 3, -1, c + 3 + DB);
        wait_q("plug_loss", 30);
        chk("loss_rstn", int'(bus.rst_n[3]), 0);
        chk("loss_ready", int'(bus.ready[3]), 0);

        // Fault holds off re-power until the request is cycled.
        bus.plug[3] = 1'b1;
        repeat (2 + DB + 8) tick();
        chk("fault_hold_en", int'(bus.en[3]), 0);
        chk("fault_hold_flt", int'(bus.fault[3]), 1);
        c = cyc;
        bus.run_req = 9'h104;
        push(EV_FAULT_DN, 3, -1, c + 1);
        tick();
        bus.run_req = 9'h10C;
        push(EV_EN_UP, 3, -1, c + 2);
        push(EV_RSTN_UP, 3, SETTLE, -1);
        wait_q("fault_recover", 40);

        // Abort chain 5 mid-settle; gap is still served and chain 6 follows.
        repeat (6) tick();
        c = cyc;
        bus.run_req = 9'h16C;
        push(EV_EN_UP, 5, -1, c + 1);
        wait_en(5, 10);
        g = cyc;
        repeat (3) tick();
        bus.run_req = 9'h14C;
        push(EV_EN_DN, 5, -1, g + 4);
        push(EV_EN_UP, 6, -1, g + 9);
        push(EV_RSTN_UP, 6, SETTLE, -1);
        tick();
        chk("abort_en5", int'(bus.en[5]), 0);
        chk("abort_rstn5", int'(bus.rst_n[5]), 0);
        chk("abort_busy", int'(bus.busy), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_gap_busy", int'(bus.busy), 1);
        end
        tick();
        chk("abort_scan_busy", int'(bus.busy), 0);
        wait_q("after_abort", 40);

        // Reset in the middle of chain 1's settle, then restart from chain 0.
        repeat (6) tick();
        c = cyc;
        bus.run_req = 9'h14E;
        push(EV_EN_UP, 1, -1, c + 1);
        wait_en(1, 10);
        g = cyc;
        repeat (3) tick();
        rst = 1'b1;
        bus.run_req = 9'h1FF;
        push(EV_EN_DN, 1, -1, g + 4);
        push(EV_EN_DN, 2, -1, g + 4);
        push(EV_EN_DN, 3, -1, g + 4);
        push(EV_EN_DN, 6, -1, g + 4);
        push(EV_EN_DN, 8, -1, g + 4);
        tick();
        chk("midrst_en", int'(bus.en), 0);
        chk("midrst_rstn", int'(bus.rst_n), 0);
        chk("midrst_ready", int'(bus.ready), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        tick();
        c = cyc;
        rst = 1'b0;
        push(EV_EN_UP, 0, -1, c + 3 + DB);
        push(EV_RSTN_UP, 0, SETTLE, -1);
        push(EV_EN_UP, 1, GAPC + 1, -1);
        push(EV_RSTN_UP, 1, SETTLE, -1);
        wait_q("restart", 80);
        bus.run_req = 9'h003;
        repeat (10) tick();
        chk("final_ready", int'(bus.ready), 9'h003);
        chk("final_busy", int'(bus.busy), 0);
        chk("final_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
